riscv_datapath: RTL and testbench

//  Single-cycle RV32I subset core: PC register, decoder/control, register file, immediate

---
 rtl/riscv_datapath_pkg.sv | 67 ++++++
 rtl/riscv_regfile.sv | 31 +++
 rtl/riscv_datapath.sv | 161 ++++++++++++++++
 tb/tb_riscv_datapath.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_datapath_pkg.sv
// Shared definitions for the single-cycle RV32I subset core:
// opcodes, control enums, the decoded control bundle and the immediate generator.
package riscv_datapath_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU,
        RES_MEM,
        RES_PC4
    } result_src_e;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        alu_ctrl_e   alu_ctrl;
        result_src_e result_src;
        imm_type_e   imm_type;
    } ctrl_t;

    // All-zero bundle: no state change, PC simply advances by 4.
    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic [XLEN-1:0] imm_ext(input logic [XLEN-1:0] instr,
                                                input imm_type_e       sel);
        logic [XLEN-1:0] imm;
        case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear, x0 hardwired to zero.
module riscv_regfile
    import riscv_datapath_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] ra1_i,
    input  logic [REG_ADDR_W-1:0] ra2_i,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] wa_i,
    input  logic [XLEN-1:0]       wd_i,
    output logic [XLEN-1:0]       rd1_o,
    output logic [XLEN-1:0]       rd2_o
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            regs_q <= '{default: '0};
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/riscv_datapath.sv
// Single-cycle RV32I subset core: PC register, decoder, register file, immediate
// generator, ALU and result/next-PC muxing; one instruction retires per clock.
module riscv_datapath
    import riscv_datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PC,
    input  logic [31:0] Instr,
    output logic [31:0] ALUResult,
    output logic [31:0] WriteData,
    output logic        MemWrite,
    input  logic [31:0] ReadData
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;

    ctrl_t                 ctrl;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       src_a;
    logic [XLEN-1:0]       rs2_val;
    logic [XLEN-1:0]       src_b;
    logic [XLEN-1:0]       alu_result;
    logic                  zero;
    logic [XLEN-1:0]       result;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       pc_target;
    logic                  pc_src;
    logic [XLEN-1:0]       pc_d;
    logic [XLEN-1:0]       pc_q;

    assign opcode   = Instr[6:0];
    assign rd       = Instr[11:7];
    assign funct3   = Instr[14:12];
    assign rs1      = Instr[19:15];
    assign rs2      = Instr[24:20];
    assign funct7b5 = Instr[30];

    // Unsupported opcode/funct3 combinations fall back to CTRL_NOP.
    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                case (funct3)
                    3'b000:  ctrl.alu_ctrl = funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl.alu_ctrl = ALU_SLL;
                    3'b010:  ctrl.alu_ctrl = ALU_SLT;
                    3'b110:  ctrl.alu_ctrl = ALU_OR;
                    3'b111:  ctrl.alu_ctrl = ALU_AND;
                    default: ctrl          = CTRL_NOP;
                endcase
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_type  = IMM_I;
                case (funct3)
                    3'b000:  ctrl.alu_ctrl = ALU_ADD;
                    3'b010:  ctrl.alu_ctrl = ALU_SLT;
                    3'b110:  ctrl.alu_ctrl = ALU_OR;
                    3'b111:  ctrl.alu_ctrl = ALU_AND;
                    default: ctrl          = CTRL_NOP;
                endcase
            end
            OP_LW: begin
                if (funct3 == 3'b010) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.imm_type   = IMM_I;
                    ctrl.result_src = RES_MEM;
                end
            end
            OP_SW: begin
                if (funct3 == 3'b010) begin
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.imm_type  = IMM_S;
                end
            end
            OP_BEQ: begin
                if (funct3 == 3'b000) begin
                    ctrl.branch   = 1'b1;
                    ctrl.alu_ctrl = ALU_SUB;
                    ctrl.imm_type = IMM_B;
                end
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.imm_type   = IMM_J;
                ctrl.result_src = RES_PC4;
            end
            default: ;
        endcase
    end

    riscv_regfile u_regfile (
        .clk_i   (clk),
        .rst_n_i (reset),
        .ra1_i   (rs1),
        .ra2_i   (rs2),
        .we_i    (ctrl.reg_write),
        .wa_i    (rd),
        .wd_i    (result),
        .rd1_o   (src_a),
        .rd2_o   (rs2_val)
    );

    assign imm   = imm_ext(Instr, ctrl.imm_type);
    assign src_b = ctrl.alu_src ? imm : rs2_val;

    always_comb begin
        case (ctrl.alu_ctrl)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
            ALU_SLL: alu_result = src_a << src_b[4:0];
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    always_comb begin
        case (ctrl.result_src)
            RES_ALU: result = alu_result;
            RES_MEM: result = ReadData;
            RES_PC4: result = pc_plus4;
            default: result = alu_result;
        endcase
    end

    assign pc_plus4  = pc_q + 32'd4;
    assign pc_target = pc_q + imm;
    assign pc_src    = ctrl.jump | (ctrl.branch & zero);
    assign pc_d      = pc_src ? pc_target : pc_plus4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC        = pc_q;
    assign ALUResult = alu_result;
    assign WriteData = rs2_val;
    assign MemWrite  = ctrl.mem_write & reset;

endmodule

// File: tb/tb_riscv_datapath.sv
// Directed program plus randomized instruction stream for riscv_datapath, checked
// against an instruction-level architectural model (registers, memory, PC).
module tb_riscv_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;

    logic [31:0] dmem [64] = '{default: '0};

    int checks   = 0;
    int failures = 0;

    // Architectural model state and the expectations for the current instruction.
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [64];
    logic [31:0] m_pc;
    logic [31:0] e_alu;
    logic        e_alu_valid;
    logic        e_mw;
    logic [31:0] e_wd;
    logic [31:0] e_npc;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_val;

    riscv_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .PC        (PC),
        .Instr     (Instr),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData)
    );

    always #5 clk = ~clk;

    assign ReadData = dmem[ALUResult[7:2]];

    always @(posedge clk) begin
        if (MemWrite) dmem[ALUResult[7:2]] <= WriteData;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = '0;
    endtask

    task automatic model_eval(input logic [31:0] ins);
        logic [31:0] a, b, imm_i, imm_s, imm_b, imm_j;
        logic [2:0]  f3;
        a     = m_regs[ins[19:15]];
        b     = m_regs[ins[24:20]];
        f3    = ins[14:12];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        e_wd = b; e_mw = 1'b0; e_we = 1'b0; e_alu_valid = 1'b0; e_alu = '0;
        e_npc = m_pc + 32'd4; e_rd = ins[11:7]; e_val = '0;
        case (ins[6:0])
            7'h33: begin
                e_alu_valid = 1'b1;
                case (f3)
                    3'd0:    e_alu = ins[30] ? a - b : a + b;
                    3'd1:    e_alu = a << b[4:0];
                    3'd2:    e_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd6:    e_alu = a | b;
                    3'd7:    e_alu = a & b;
                    default: e_alu_valid = 1'b0;
                endcase
                e_we = e_alu_valid; e_val = e_alu;
            end
            7'h13: begin
                e_alu_valid = 1'b1;
                case (f3)
                    3'd0:    e_alu = a + imm_i;
                    3'd2:    e_alu = ($signed(a) < $signed(imm_i)) ? 32'd1 : 32'd0;
                    3'd6:    e_alu = a | imm_i;
                    3'd7:    e_alu = a & imm_i;
                    default: e_alu_valid = 1'b0;
                endcase
                e_we = e_alu_valid; e_val = e_alu;
            end
            7'h03: if (f3 == 3'd2) begin
                e_alu = a + imm_i; e_alu_valid = 1'b1;
                e_we = 1'b1; e_val = m_mem[e_alu[7:2]];
            end
            7'h23: if (f3 == 3'd2) begin
                e_alu = a + imm_s; e_alu_valid = 1'b1; e_mw = 1'b1;
            end
            7'h63: if (f3 == 3'd0) begin
                e_alu = a - b; e_alu_valid = 1'b1;
                if (a == b) e_npc = m_pc + imm_b;
            end
            7'h6f: begin
                e_we = 1'b1; e_val = m_pc + 32'd4; e_npc = m_pc + imm_j;
            end
            default: ;
        endcase
    endtask

    task automatic apply(input logic [31:0] ins);
        Instr = ins;
        #1;
        model_eval(ins);
        chk("pc", PC, m_pc);
        chk("memwrite", {31'b0, MemWrite}, {31'b0, e_mw});
        chk("writedata", WriteData, e_wd);
        if (e_alu_valid) chk("aluresult", ALUResult, e_alu);
    endtask

    task automatic tick();
        @(posedge clk);
        m_pc = e_npc;
        if (e_we && e_rd != 5'd0) m_regs[e_rd] = e_val;
        if (e_mw) m_mem[e_alu[7:2]] = e_wd;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [20:0] imm;
        logic [6:0]  op;
        logic [31:0] ins;
        int          k;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = 21'($urandom);
        k   = int'($urandom_range(0, 9));
        case (k)
            0, 1: begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0; 1: f3 = 3'd0; 2: f3 = 3'd1;
                    3: f3 = 3'd2; 4: f3 = 3'd6; default: f3 = 3'd7;
                endcase
                ins = {1'b0, (f3 == 3'd0) ? 1'($urandom) : 1'b0, 5'b0, rs2, rs1, f3, rd, 7'h33};
            end
            2, 3: begin
                case ($urandom_range(0, 3))
                    0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd6; default: f3 = 3'd7;
                endcase
                ins = {imm[11:0], rs1, f3, rd, 7'h13};
            end
            4: ins = {imm[11:0], rs1, 3'b010, rd, 7'h03};
            5: ins = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            6: begin
                if ($urandom_range(0, 1) == 1) rs2 = rs1;
                ins = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
            end
            7: ins = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
            8: begin
                f3 = 3'($urandom_range(3, 5));
                ins = ($urandom_range(0, 1) == 1) ? {7'b0, rs2, rs1, f3, rd, 7'h33}
                                                  : {imm[11:0], rs1, (f3 == 3'd3) ? 3'd1 : f3, rd, 7'h13};
            end
            default: begin
                op = 7'($urandom);
                if (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 ||
                    op == 7'h63 || op == 7'h6f) op = op ^ 7'h04;
                ins = {25'($urandom), op};
            end
        endcase
        return ins;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        model_reset();
        reset = 1'b0;
        Instr = 32'h00302023;

        // Reset held for two cycles; a store presented meanwhile must not write.
        #1;
        chk("reset_pc", PC, 32'h0);
        chk("reset_memwrite", {31'b0, MemWrite}, 32'h0);
        @(posedge clk); #1;
        chk("reset_pc_edge1", PC, 32'h0);
        @(posedge clk); #1;
        chk("reset_pc_edge2", PC, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        apply(32'h00500093); chk("addi_x1", ALUResult, 32'd5);  chk("pc0", PC, 32'd0); tick();
        chk("pc_after_first", PC, 32'd4);
        apply(32'h00a00113); chk("addi_x2", ALUResult, 32'd10); tick();
        apply(32'h002081b3); chk("add_x3", ALUResult, 32'd15);  chk("pc8", PC, 32'd8); tick();
        apply(32'h40110233); chk("sub_x4", ALUResult, 32'd5);   tick();
        apply(32'h00302023);
        chk("sw_mw", {31'b0, MemWrite}, 32'd1);
        chk("sw_addr", ALUResult, 32'd0);
        chk("sw_data", WriteData, 32'd15);
        tick();
        apply(32'h00002303); chk("lw_mw", {31'b0, MemWrite}, 32'd0); tick();
        apply(32'h000303b3); chk("lw_value_via_add", ALUResult, 32'd15); tick();
        apply(32'h00330463); chk("beq_pc", PC, 32'd28); tick();
        chk("beq_taken", PC, 32'd36);
        apply(32'h002091b3); chk("sll_x3", ALUResult, 32'h0000_1400); tick();
        apply(32'h00330463); tick();
        chk("beq_not_taken", PC, 32'd44);
        apply(32'h00108093); chk("addi_reads_old", ALUResult, 32'd6); tick();
        apply(32'h00700013); tick();
        apply(32'h00002023); chk("x0_reads_zero", WriteData, 32'd0); tick();
        apply(32'hffff_ffff); chk("nop_mw", {31'b0, MemWrite}, 32'd0); tick();
        chk("nop_pc", PC, 32'd60);

        for (int i = 0; i < 5; i++) begin
            apply(32'h0000006f);
            tick();
            chk("jal_self_loop", PC, 32'd60);
        end

        // Reset asserted between clock edges must take effect immediately.
        apply(32'h00302023);
        #2 reset = 1'b0;
        #1;
        chk("midreset_pc", PC, 32'd0);
        chk("midreset_mw", {31'b0, MemWrite}, 32'd0);
        chk("midreset_regs", WriteData, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < 400; n++) begin
            apply(rand_instr());
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
